// File: rtl/isa_pkg.sv
// Shared ISA definitions: widths, opcodes and fetch-state encoding.
package isa_pkg;

  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_ADD, OP_SUB,
    OP_ADDI, OP_MOV3, OP_MOV2, OP_CMP,
    OP_SHIFT, OP_BEQ, OP_BGE, OP_BLE,
    OP_BRANCH, OP_STORE, OP_LOAD, OP_HALT
  } opcode_e;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_DONE
  } fetch_state_e;

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: registered entries, one write port,
// combinational read port.
module branch_lut #(
  parameter int AW = 5,
  parameter int DW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with
// table-driven branches and a saturating RUN-cycle counter.
module fetch_sequencer #(
  parameter int PC_W   = isa_pkg::PC_W,
  parameter int LUT_AW = isa_pkg::LUT_AW,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Branch,
  input  logic              Halt,
  input  logic [LUT_AW-1:0] BranchIdx,
  input  logic              LutWrEn,
  input  logic [LUT_AW-1:0] LutWrAddr,
  input  logic [PC_W-1:0]   LutWrData,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  import isa_pkg::*;

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  lut_rd;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             run_q;
  logic             done_q;
  logic             lut_we;

  // Table is frozen while a program runs, so reads never race writes.
  assign lut_we = LutWrEn && (state_q != FS_RUN);

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .we_i    (lut_we),
    .waddr_i (LutWrAddr),
    .wdata_i (LutWrData),
    .raddr_i (BranchIdx),
    .rdata_o (lut_rd)
  );

  always_comb begin
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    pc_d  = Branch ? lut_rd : pc_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FS_IDLE, FS_DONE: begin
          if (Start) begin
            state_q <= FS_RUN;
            pc_q    <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FS_RUN: begin
          cnt_q <= cnt_d;
          if (Halt) begin
            state_q <= FS_DONE;
            run_q   <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
          state_q <= FS_IDLE;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign Running    = run_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_fetch_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic       Branch;
  logic       Halt;
  logic [4:0] BranchIdx;
  logic       LutWrEn;
  logic [4:0] LutWrAddr;
  logic [9:0] LutWrData;
  logic [9:0] PC;
  logic       Running;
  logic       Done;
  logic [15:0] CycleCount;

  int tests;
  int fails;

  // Behavioural model
  bit          m_running;
  bit          m_done;
  logic [9:0]  m_pc;
  logic [15:0] m_cnt;
  logic [9:0]  m_lut [32];

  fetch_sequencer dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Branch     (Branch),
    .Halt       (Halt),
    .BranchIdx  (BranchIdx),
    .LutWrEn    (LutWrEn),
    .LutWrAddr  (LutWrAddr),
    .LutWrData  (LutWrData),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic idle_inputs();
    Start     = 1'b0;
    Branch    = 1'b0;
    Halt      = 1'b0;
    BranchIdx = '0;
    LutWrEn   = 1'b0;
    LutWrAddr = '0;
    LutWrData = '0;
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_done    = 1'b0;
    m_pc      = '0;
    m_cnt     = '0;
    for (int i = 0; i < 32; i++) m_lut[i] = '0;
  endtask

  // Advance one clock: update the model from current inputs,
  // then sample 1 time unit after the rising edge.
  task automatic tick();
    if (!m_running) begin
      if (LutWrEn) m_lut[LutWrAddr] = LutWrData;
      if (Start) begin
        m_running = 1'b1;
        m_done    = 1'b0;
        m_pc      = '0;
        m_cnt     = '0;
      end
    end else begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (Halt) begin
        m_running = 1'b0;
        m_done    = 1'b1;
      end else if (Branch) begin
        m_pc = m_lut[BranchIdx];
      end else begin
        m_pc = m_pc + 10'd1;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset_n = 1'b0;
    model_reset();
    #3;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic lut_write(input int a, input int d);
    LutWrEn   = 1'b1;
    LutWrAddr = 5'(a);
    LutWrData = 10'(d);
    tick();
    LutWrEn   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset_n = 1'b0;
    model_reset();
    #3;
    tests++;
    if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 ||
        CycleCount !== 16'd0) begin
      fails++;
      $display("FAIL reset: pc=%h run=%b done=%b cnt=%0d exp 0/0/0/0",
               PC, Running, Done, CycleCount);
    end
    Reset_n = 1'b1;
    tick();
    tick();
    tests++;
    if (Running !== 1'b0 || PC !== 10'd0) begin
      fails++;
      $display("FAIL reset_idle: run=%b pc=%h exp run=0 pc=0",
               Running, PC);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tests++;
      if (PC !== 10'(i) || Running !== 1'b1 || CycleCount !== 16'(i)) begin
        fails++;
        $display("FAIL seq[%0d]: pc=%h run=%b cnt=%0d exp pc=%h run=1 cnt=%0d",
                 i, PC, Running, CycleCount, 10'(i), i);
      end
      if (i < 5) tick();
    end
  endtask

  task automatic test_branch();
    do_reset();
    lut_write(3, 'h120);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tests++;
    if (PC !== 10'd2) begin
      fails++;
      $display("FAIL branch_pre: pc=%h exp 002", PC);
    end
    Branch    = 1'b1;
    BranchIdx = 5'd3;
    tick();
    Branch = 1'b0;
    tests++;
    if (PC !== 10'h120 || Running !== 1'b1) begin
      fails++;
      $display("FAIL branch: pc=%h run=%b exp pc=120 run=1", PC, Running);
    end
    tick();
    tests++;
    if (PC !== 10'h121) begin
      fails++;
      $display("FAIL branch_next: pc=%h exp 121", PC);
    end
  endtask

  task automatic test_halt_priority();
    do_reset();
    lut_write(5, 'h2AA);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    Halt      = 1'b1;
    Branch    = 1'b1;
    BranchIdx = 5'd5;
    tick();
    idle_inputs();
    tests++;
    if (Done !== 1'b1 || Running !== 1'b0 || PC !== 10'd7 ||
        CycleCount !== 16'd8) begin
      fails++;
      $display("FAIL halt: done=%b run=%b pc=%h cnt=%0d exp 1/0/007/8",
               Done, Running, PC, CycleCount);
    end
    Branch    = 1'b1;
    Halt      = 1'b1;
    BranchIdx = 5'd5;
    tick();
    tick();
    idle_inputs();
    tests++;
    if (Done !== 1'b1 || PC !== 10'd7 || CycleCount !== 16'd8) begin
      fails++;
      $display("FAIL done_hold: done=%b pc=%h cnt=%0d exp 1/007/8",
               Done, PC, CycleCount);
    end
  endtask

  task automatic test_lut_write_ignored();
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    lut_write(0, 'h055);
    tests++;
    if (PC !== 10'd1) begin
      fails++;
      $display("FAIL lutrun_pc: pc=%h exp 001", PC);
    end
    Branch    = 1'b1;
    BranchIdx = 5'd0;
    tick();
    Branch = 1'b0;
    tests++;
    if (PC !== 10'h000) begin
      fails++;
      $display("FAIL lutrun_ignored: pc=%h exp 000", PC);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    lut_write(7, 'h3FF);
    Start = 1'b1;
    tick();
    Start     = 1'b0;
    Branch    = 1'b1;
    BranchIdx = 5'd7;
    tick();
    Branch = 1'b0;
    tests++;
    if (PC !== 10'h3FF) begin
      fails++;
      $display("FAIL wrap_pre: pc=%h exp 3ff", PC);
    end
    tick();
    tests++;
    if (PC !== 10'h000 || Running !== 1'b1) begin
      fails++;
      $display("FAIL wrap: pc=%h run=%b exp pc=000 run=1", PC, Running);
    end
    tick();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (PC !== 10'd0 || Running !== 1'b0 || Done !== 1'b0 ||
        CycleCount !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: pc=%h run=%b done=%b cnt=%0d exp 0/0/0/0",
               PC, Running, Done, CycleCount);
    end
    Reset_n   = 1'b1;
    Branch    = 1'b1;
    Halt      = 1'b0;
    BranchIdx = 5'd7;
    tick();
    tick();
    idle_inputs();
    tests++;
    if (Running !== 1'b0 || Done !== 1'b0 || PC !== 10'd0) begin
      fails++;
      $display("FAIL post_reset_idle: run=%b done=%b pc=%h exp 0/0/000",
               Running, Done, PC);
    end
  endtask

  task automatic test_restart();
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    Halt = 1'b1;
    tick();
    Halt  = 1'b0;
    Start = 1'b1;
    tick();
    tests++;
    if (Running !== 1'b1 || Done !== 1'b0 || PC !== 10'd0 ||
        CycleCount !== 16'd0) begin
      fails++;
      $display("FAIL restart: run=%b done=%b pc=%h cnt=%0d exp 1/0/000/0",
               Running, Done, PC, CycleCount);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++;
      if (PC !== 10'(i) || CycleCount !== 16'(i) || Running !== 1'b1) begin
        fails++;
        $display("FAIL start_held[%0d]: pc=%h cnt=%0d run=%b exp pc=%h cnt=%0d",
                 i, PC, CycleCount, Running, 10'(i), i);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 65540; i++) tick();
    tests++;
    if (CycleCount !== 16'hFFFF || Running !== 1'b1) begin
      fails++;
      $display("FAIL saturate: cnt=%h run=%b exp ffff/1", CycleCount, Running);
    end
    Halt = 1'b1;
    tick();
    Halt = 1'b0;
    tests++;
    if (CycleCount !== 16'hFFFF || Done !== 1'b1 || PC !== m_pc) begin
      fails++;
      $display("FAIL saturate_halt: cnt=%h done=%b pc=%h exp ffff/1/%h",
               CycleCount, Done, PC, m_pc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      Start     = ($urandom_range(0, 15) == 0);
      Halt      = ($urandom_range(0, 24) == 0);
      Branch    = ($urandom_range(0, 3) == 0);
      BranchIdx = 5'($urandom_range(0, 31));
      LutWrEn   = ($urandom_range(0, 2) == 0);
      LutWrAddr = 5'($urandom_range(0, 31));
      LutWrData = 10'($urandom_range(0, 1023));
      tick();
      tests++;
      if (PC !== m_pc || Running !== m_running || Done !== m_done ||
          CycleCount !== m_cnt) begin
        fails++;
        $display("FAIL rand[%0d]: pc=%h run=%b done=%b cnt=%0d exp pc=%h run=%b done=%b cnt=%0d",
                 n, PC, Running, Done, CycleCount,
                 m_pc, m_running, m_done, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    Reset_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_halt_priority();
    test_lut_write_ignored();
    test_wrap_and_async_reset();
    test_restart();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- PC_W, 10, program-counter width
- LUT_AW, 5, branch-target table address width (32 entries)
- CNT_W, 16, cycle-counter width
REQ-002 The block SHALL expose these ports, one per line: name, direction, width, meaning.
- Clk, in, 1, single clock; all state changes on the rising edge
- Reset_n, in, 1, asynchronous active-low reset
- Start, in, 1, program-start request
- Branch, in, 1, take-branch from the control decoder
- Halt, in, 1, halt from the control decoder
- BranchIdx, in, LUT_AW, target-table index (instruction bits [4:0])
- LutWrEn, in, 1, target-table write strobe
- LutWrAddr, in, LUT_AW, target-table write address
- LutWrData, in, PC_W, target-table write data (absolute PC)
- PC, out, PC_W, instruction-memory fetch address
- Running, out, 1, high while in RUN
- Done, out, 1, high while in DONE
- CycleCount, out, CNT_W, number of RUN cycles executed

Function
REQ-003 The block SHALL implement three states: IDLE, RUN, DONE.
REQ-004 In IDLE, Start=1 SHALL move the block to RUN on the next edge, with PC=0 and CycleCount=0.
REQ-005 In RUN with Halt=1, the next state SHALL be DONE and PC SHALL hold its value.
REQ-006 In RUN with Halt=0 and Branch=1, PC SHALL load the target-table entry at BranchIdx on the next edge.
REQ-007 In RUN with Halt=0 and Branch=0, PC SHALL increment by 1, wrapping from 2^PC_W-1 to 0.
REQ-008 When Halt and Branch are both 1, Halt SHALL take priority and the branch SHALL be ignored.
REQ-009 CycleCount SHALL increment on every edge taken in RUN, including the halting edge, and SHALL saturate at 2^CNT_W-1.
REQ-010 In DONE, Done SHALL be 1, and PC and CycleCount SHALL hold.
REQ-011 In DONE, Start=1 SHALL restart the block: next state RUN, PC=0, CycleCount=0.
REQ-012 Start SHALL be ignored while in RUN.
REQ-013 Target-table writes SHALL take effect only in IDLE or DONE; LutWrEn SHALL be ignored in RUN.
REQ-014 The target-table read SHALL be combinational on BranchIdx. A write and a branch read SHALL never coincide, per REQ-013.
REQ-015 Running and Done SHALL be registered state decodes, with zero-cycle latency after each state change.
REQ-016 Branch, Halt and BranchIdx SHALL be ignored outside RUN.

Reset
REQ-017 Reset_n=0 SHALL asynchronously force: state IDLE, PC=0, CycleCount=0, Running=0, Done=0, all target-table entries 0.
REQ-018 Reset asserted mid-RUN SHALL abort the program; after release, the block SHALL remain in IDLE until Start.
REQ-019 Reset deassertion SHALL be synchronous to Clk; the first possible state change is at the first edge after release.

Structure
REQ-020 The following SHALL live in the shared isa_pkg package:
- PC_W and LUT_AW constants
- the 4-bit opcode enum (AND, OR, ADD, SUB, ADDI, MOV3, MOV2, CMP, SHIFT, BEQ, BGE, BLE, BRANCH, STORE, LOAD, HALT)
- the fetch-state enum
REQ-021 The target table SHALL be a separate sub-module, branch_lut, containing the 32 x PC_W registers, the async reset, the write port and the combinational read port.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, then Start pulse, then 5 cycles with Branch=0 and Halt=0 -> PC sequence 0,1,2,3,4,5; Running=1.
- Load LUT[3]=0x120 in IDLE, Start, Branch=1 with BranchIdx=3 at PC=2 -> next PC=0x120.
- Halt=1 and Branch=1 together at PC=7 -> DONE, PC stays 7, Done=1, CycleCount=8.
- LutWrEn=1 during RUN writing LUT[0]=0x055, then branch via index 0 -> PC=0x000 (write ignored).
- Preset PC at 0x3FF by branch, then a non-branch cycle -> PC=0x000 (wrap); Reset_n=0 mid-RUN -> PC=0, IDLE immediately, without waiting for a clock edge.
- From DONE, Start pulse -> RUN with PC=0, CycleCount=0; Start held during RUN has no effect.
